nx_stream_distributor: RTL and testbench

Outbound counterpart to the node's inbound stream arbiter: merges the bypass stream (messages passing through this node) with the node's own emit stream and steers each message into one of four registered directional output slots (north, east, south, west). Both sources are accepted in the same cycle when they target different directions. Contention for the same direction is resolved by a two-way round-robin. Sits between the stream arbiter/node core and the mesh links.

---
 rtl/nx_stream_distributor.sv | 164 ++++++++++++++++
 tb/tb_nx_stream_distributor.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_stream_distributor.sv
// nx_stream_distributor
//
// Merges the bypass stream (traffic passing through this node) with the node's
// own emit stream and steers each message into one of four registered
// directional output slots (north, east, south, west). Both sources are accepted
// in the same cycle when they target different directions. When both target the
// same direction, a 1-bit round-robin pointer picks the winner.
//
// Optional build macro: NX_DISTRIBUTOR_STATS_EN adds saturating per-source
// accepted-message counters (bypass_count_o, emit_count_o).
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   bypass_data_i/dir_i/valid_i       bypass message, target direction, present
//   bypass_ready_o                    bypass message accepted this cycle
//   emit_data_i/dir_i/valid_i         node-originated message, direction, present
//   emit_ready_o                      emit message accepted this cycle
//   {north,east,south,west}_data_o    directional slot data
//   {north,east,south,west}_valid_o   slot holds a message
//   {north,east,south,west}_ready_i   downstream consumes the slot
//   bypass_count_o, emit_count_o      accepted-message counters (stats build only)
//   idle_o                            all slots empty and both input valids low

package nx_stream_pkg;
  typedef logic [31:0] nx_message_t;
  typedef enum logic [1:0] {
    NX_NORTH = 2'd0,
    NX_EAST  = 2'd1,
    NX_SOUTH = 2'd2,
    NX_WEST  = 2'd3
  } nx_direction_t;
endpackage

module nx_stream_distributor
  import nx_stream_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  nx_message_t            bypass_data_i,
  input  nx_direction_t          bypass_dir_i,
  input  logic                   bypass_valid_i,
  output logic                   bypass_ready_o,
  input  nx_message_t            emit_data_i,
  input  nx_direction_t          emit_dir_i,
  input  logic                   emit_valid_i,
  output logic                   emit_ready_o,
  output nx_message_t            north_data_o,
  output logic                   north_valid_o,
  input  logic                   north_ready_i,
  output nx_message_t            east_data_o,
  output logic                   east_valid_o,
  input  logic                   east_ready_i,
  output nx_message_t            south_data_o,
  output logic                   south_valid_o,
  input  logic                   south_ready_i,
  output nx_message_t            west_data_o,
  output logic                   west_valid_o,
  input  logic                   west_ready_i,
`ifdef NX_DISTRIBUTOR_STATS_EN
  output logic [COUNT_WIDTH-1:0] bypass_count_o,
  output logic [COUNT_WIDTH-1:0] emit_count_o,
`endif
  output logic                   idle_o
);

  logic [3:0]  slot_vld_p1;
  nx_message_t slot_data_p1 [4];

  logic [3:0]  ready_vec;
  logic [3:0]  slot_free;
  logic [3:0]  fill_bypass;
  logic [3:0]  fill_emit;
  logic        bypass_want;
  logic        emit_want;
  logic        conflict;
  logic        bypass_grant;
  logic        emit_grant;
  logic        last_grant;   // 0: bypass won the last conflict, 1: emit did

  // Stage p0: grant decision (combinational from inputs and slot state)
  assign ready_vec   = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};
  // A slot being drained this cycle can be refilled in the same cycle.
  assign slot_free   = ~slot_vld_p1 | ready_vec;
  assign bypass_want = bypass_valid_i && slot_free[bypass_dir_i];
  assign emit_want   = emit_valid_i && slot_free[emit_dir_i];
  assign conflict    = bypass_want && emit_want && (bypass_dir_i == emit_dir_i);

  // On a conflict the source flagged by last_grant yields.
  assign bypass_grant = bypass_want && !(conflict && !last_grant);
  assign emit_grant   = emit_want && !(conflict && last_grant);

  assign bypass_ready_o = bypass_grant;
  assign emit_ready_o   = emit_grant;

  assign fill_bypass = bypass_grant ? (4'b0001 << bypass_dir_i) : 4'b0000;
  assign fill_emit   = emit_grant ? (4'b0001 << emit_dir_i) : 4'b0000;

  // Stage p1: directional output slots
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_vld_p1 <= 4'b0000;
      for (int d = 0; d < 4; d++) begin
        slot_data_p1[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (fill_bypass[d]) begin
          slot_vld_p1[d]  <= 1'b1;
          slot_data_p1[d] <= bypass_data_i;
        end else if (fill_emit[d]) begin
          slot_vld_p1[d]  <= 1'b1;
          slot_data_p1[d] <= emit_data_i;
        end else if (ready_vec[d]) begin
          slot_vld_p1[d]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b0;
    end else if (conflict) begin
      last_grant <= emit_grant;
    end
  end

  assign north_valid_o = slot_vld_p1[0];
  assign east_valid_o  = slot_vld_p1[1];
  assign south_valid_o = slot_vld_p1[2];
  assign west_valid_o  = slot_vld_p1[3];
  assign north_data_o  = slot_data_p1[0];
  assign east_data_o   = slot_data_p1[1];
  assign south_data_o  = slot_data_p1[2];
  assign west_data_o   = slot_data_p1[3];

  assign idle_o = !(|slot_vld_p1) && !bypass_valid_i && !emit_valid_i;

`ifdef NX_DISTRIBUTOR_STATS_EN
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [COUNT_WIDTH-1:0] bypass_cnt_p1;
  logic [COUNT_WIDTH-1:0] emit_cnt_p1;

  // Stage p1: saturating accept counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bypass_cnt_p1 <= '0;
      emit_cnt_p1   <= '0;
    end else begin
      if (bypass_grant) bypass_cnt_p1 <= sat_inc(bypass_cnt_p1);
      if (emit_grant)   emit_cnt_p1   <= sat_inc(emit_cnt_p1);
    end
  end

  assign bypass_count_o = bypass_cnt_p1;
  assign emit_count_o   = emit_cnt_p1;
`endif

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Self-checking bench for nx_stream_distributor. Directed scenarios plus a
// randomized run compared against a transaction-level model (slot contents,
// round-robin pointer, per-direction order queues).

module tb_nx_stream_distributor;
  import nx_stream_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  nx_message_t   bdata = '0, edata = '0;
  nx_direction_t bdir = NX_NORTH, edir = NX_NORTH;
  logic          bv = 1'b0, ev = 1'b0;
  logic          brdy, erdy;
  logic [3:0]    rdy = 4'b0000;
  logic          ov [4];
  nx_message_t   od [4];
  logic          idle;
`ifdef NX_DISTRIBUTOR_STATS_EN
  logic [CW-1:0] bcnt, ecnt;
`endif

  always #5 clk = ~clk;

  nx_stream_distributor #(.COUNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .bypass_data_i(bdata), .bypass_dir_i(bdir), .bypass_valid_i(bv), .bypass_ready_o(brdy),
    .emit_data_i(edata), .emit_dir_i(edir), .emit_valid_i(ev), .emit_ready_o(erdy),
    .north_data_o(od[0]), .north_valid_o(ov[0]), .north_ready_i(rdy[0]),
    .east_data_o(od[1]),  .east_valid_o(ov[1]),  .east_ready_i(rdy[1]),
    .south_data_o(od[2]), .south_valid_o(ov[2]), .south_ready_i(rdy[2]),
    .west_data_o(od[3]),  .west_valid_o(ov[3]),  .west_ready_i(rdy[3]),
`ifdef NX_DISTRIBUTOR_STATS_EN
    .bypass_count_o(bcnt), .emit_count_o(ecnt),
`endif
    .idle_o(idle)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit          mv [4];
  nx_message_t md [4];
  bit          lg;
  bit          eb, ee, econf;
  nx_message_t sbq [4][$];

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      mv[d] = 0; md[d] = '0; sbq[d].delete();
    end
    lg = 0; eb = 0; ee = 0; econf = 0;
  endtask

  // Expected grants for the inputs currently applied.
  task automatic model_eval();
    bit bw, ew;
    bw = bv && (!mv[bdir] || rdy[bdir]);
    ew = ev && (!mv[edir] || rdy[edir]);
    econf = bw && ew && (bdir == edir);
    eb = bw; ee = ew;
    if (econf) begin
      if (lg) ee = 0;
      else    eb = 0;
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_adv();
    @(posedge clk);
    for (int d = 0; d < 4; d++) if (mv[d] && rdy[d]) mv[d] = 0;
    if (eb) begin mv[bdir] = 1; md[bdir] = bdata; end
    if (ee) begin mv[edir] = 1; md[edir] = edata; end
    if (econf) lg = ee;
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic drive(input bit b_v, input nx_direction_t b_d, input nx_message_t b_x,
                       input bit e_v, input nx_direction_t e_d, input nx_message_t e_x);
    bv = b_v; bdir = b_d; bdata = b_x;
    ev = e_v; edir = e_d; edata = e_x;
  endtask

  task automatic do_reset();
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    rst = 1;
    #2;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (ov[d] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", d, ov[d]);
      else n_pass++;
      n_chk++;
      if (od[d] !== 32'h0) $display("FAIL reset_data[%0d]: got %h want 0", d, od[d]);
      else n_pass++;
    end
    n_chk++;
    if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle);
    else n_pass++;
    n_chk++;
    if ({brdy, erdy} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {brdy, erdy});
    else n_pass++;
`ifdef NX_DISTRIBUTOR_STATS_EN
    n_chk++;
    if ({bcnt, ecnt} !== '0) $display("FAIL reset_counts: got %h/%h want 0/0", bcnt, ecnt);
    else n_pass++;
`endif
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_single_route();
    rdy = 4'b0010;
    drive(1, NX_EAST, 32'h1234, 0, NX_NORTH, '0);
    settle();
    n_chk++;
    if (brdy !== 1'b1) $display("FAIL single_bready: got %b want 1", brdy);
    else n_pass++;
    n_chk++;
    if (idle !== 1'b0) $display("FAIL single_idle: got %b want 0", idle);
    else n_pass++;
    model_adv();
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    settle();
    n_chk++;
    if (ov[1] !== 1'b1 || od[1] !== 32'h1234)
      $display("FAIL single_east: got v=%b d=%h want v=1 d=00001234", ov[1], od[1]);
    else n_pass++;
    n_chk++;
    if ({ov[3], ov[2], ov[0]} !== 3'b000)
      $display("FAIL single_others: got %b want 000", {ov[3], ov[2], ov[0]});
    else n_pass++;
    model_adv();
  endtask

  task automatic test_dual_issue();
    do_reset();
    rdy = 4'b1111;
    drive(1, NX_NORTH, 32'hAAAA_0001, 1, NX_SOUTH, 32'hBBBB_0002);
    settle();
    n_chk++;
    if ({brdy, erdy} !== 2'b11) $display("FAIL dual_ready: got %b want 11", {brdy, erdy});
    else n_pass++;
    model_adv();
    // Next cycle both target EAST: last_grant untouched by dual issue, so emit wins.
    drive(1, NX_EAST, 32'hAAAA_0003, 1, NX_EAST, 32'hBBBB_0004);
    settle();
    n_chk++;
    if (ov[0] !== 1'b1 || od[0] !== 32'hAAAA_0001)
      $display("FAIL dual_north: got v=%b d=%h want v=1 d=aaaa0001", ov[0], od[0]);
    else n_pass++;
    n_chk++;
    if (ov[2] !== 1'b1 || od[2] !== 32'hBBBB_0002)
      $display("FAIL dual_south: got v=%b d=%h want v=1 d=bbbb0002", ov[2], od[2]);
    else n_pass++;
    n_chk++;
    if ({brdy, erdy} !== 2'b01) $display("FAIL dual_lastgrant: got %b want 01", {brdy, erdy});
    else n_pass++;
    model_adv();
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    model_adv();
  endtask

  task automatic test_conflict_rr();
    bit          want_emit [4] = '{1, 0, 1, 0};
    nx_message_t prev;
    do_reset();
    rdy = 4'b1000;
    drive(1, NX_WEST, 32'hB000_0000, 1, NX_WEST, 32'hE000_0000);
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_chk++;
      if (erdy !== want_emit[k] || brdy !== !want_emit[k])
        $display("FAIL rr_grant[%0d]: got b=%b e=%b want e=%b", k, brdy, erdy, want_emit[k]);
      else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (ov[3] !== 1'b1 || od[3] !== prev)
          $display("FAIL rr_west[%0d]: got v=%b d=%h want v=1 d=%h", k, ov[3], od[3], prev);
        else n_pass++;
      end
      prev = want_emit[k] ? edata : bdata;
      model_adv();
      if (want_emit[k]) edata = edata + 1;
      else              bdata = bdata + 1;
    end
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    settle();
    n_chk++;
    if (ov[3] !== 1'b1 || od[3] !== prev)
      $display("FAIL rr_west_last: got v=%b d=%h want v=1 d=%h", ov[3], od[3], prev);
    else n_pass++;
    model_adv();
  endtask

  task automatic test_backpressure();
    nx_message_t msg [4] = '{32'h5000_000A, 32'h5000_000B, 32'h5000_000C, 32'h5000_000D};
    do_reset();
    rdy = 4'b1011;
    drive(1, NX_SOUTH, msg[0], 0, NX_NORTH, '0);
    settle();
    n_chk++;
    if (brdy !== 1'b1) $display("FAIL bp_first: got %b want 1", brdy);
    else n_pass++;
    model_adv();
    bdata = msg[1];
    for (int k = 0; k < 2; k++) begin
      settle();
      n_chk++;
      if (brdy !== 1'b0 || ov[2] !== 1'b1 || od[2] !== msg[0])
        $display("FAIL bp_stall[%0d]: got r=%b v=%b d=%h want r=0 v=1 d=%h",
                 k, brdy, ov[2], od[2], msg[0]);
      else n_pass++;
      model_adv();
    end
    rdy = 4'b1111;
    for (int k = 1; k < 4; k++) begin
      bdata = msg[k];
      settle();
      n_chk++;
      if (brdy !== 1'b1 || ov[2] !== 1'b1 || od[2] !== msg[k-1])
        $display("FAIL bp_drain[%0d]: got r=%b v=%b d=%h want r=1 v=1 d=%h",
                 k, brdy, ov[2], od[2], msg[k-1]);
      else n_pass++;
      model_adv();
    end
    bv = 0;
    settle();
    n_chk++;
    if (ov[2] !== 1'b1 || od[2] !== msg[3])
      $display("FAIL bp_tail: got v=%b d=%h want v=1 d=%h", ov[2], od[2], msg[3]);
    else n_pass++;
    model_adv();
    settle();
    n_chk++;
    if (ov[2] !== 1'b0) $display("FAIL bp_empty: got %b want 0", ov[2]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    rdy = 4'b0000;
    drive(1, NX_NORTH, 32'h0000_00A1, 1, NX_EAST, 32'h0000_00E1);
    settle();
    model_adv();
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    #1;
    n_chk++;
    if ({ov[1], ov[0]} !== 2'b11) $display("FAIL areset_pre: got %b want 11", {ov[1], ov[0]});
    else n_pass++;
    #2 rst = 1;
    #1;
    n_chk++;
    if ({ov[3], ov[2], ov[1], ov[0]} !== 4'b0000 || idle !== 1'b1)
      $display("FAIL areset_drop: got v=%b idle=%b want v=0000 idle=1",
               {ov[3], ov[2], ov[1], ov[0]}, idle);
    else n_pass++;
    #2 rst = 0;
    model_clear();
    rdy = 4'b1111;
    drive(1, NX_NORTH, 32'h0000_00A2, 0, NX_NORTH, '0);
    settle();
    n_chk++;
    if (brdy !== 1'b1 || ov[0] !== 1'b0)
      $display("FAIL areset_accept: got r=%b v=%b want r=1 v=0", brdy, ov[0]);
    else n_pass++;
    model_adv();
    bv = 0;
    settle();
    n_chk++;
    if (ov[0] !== 1'b1 || od[0] !== 32'h0000_00A2 || ov[1] !== 1'b0)
      $display("FAIL areset_after: got nv=%b nd=%h ev=%b want 1 000000a2 0", ov[0], od[0], ov[1]);
    else n_pass++;
    model_adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      if (!bv || eb)
        drive($urandom_range(0, 3) != 0, nx_direction_t'($urandom_range(0, 3)), $urandom(),
              ev, edir, edata);
      if (!ev || ee) begin
        ev = $urandom_range(0, 3) != 0;
        edir = nx_direction_t'($urandom_range(0, 3));
        edata = $urandom();
      end
      settle();
      n_chk++;
      if (brdy !== eb || erdy !== ee)
        $display("FAIL rnd_ready[%0d]: got b=%b e=%b want b=%b e=%b", c, brdy, erdy, eb, ee);
      else n_pass++;
      for (int d = 0; d < 4; d++) begin
        n_chk++;
        if (ov[d] !== mv[d] || (mv[d] && od[d] !== md[d]))
          $display("FAIL rnd_slot[%0d][%0d]: got v=%b d=%h want v=%b d=%h",
                   c, d, ov[d], od[d], mv[d], md[d]);
        else n_pass++;
        if (ov[d] === 1'b1 && rdy[d]) begin
          n_chk++;
          if (sbq[d].size() == 0) $display("FAIL rnd_order[%0d][%0d]: got %h want none", c, d, od[d]);
          else if (od[d] !== sbq[d][0]) $display("FAIL rnd_order[%0d][%0d]: got %h want %h", c, d, od[d], sbq[d][0]);
          else n_pass++;
          if (sbq[d].size() != 0) void'(sbq[d].pop_front());
        end
      end
      n_chk++;
      if (idle !== (!(mv[0] || mv[1] || mv[2] || mv[3]) && !bv && !ev))
        $display("FAIL rnd_idle[%0d]: got %b", c, idle);
      else n_pass++;
      if (eb) sbq[bdir].push_back(bdata);
      if (ee) sbq[edir].push_back(edata);
      model_adv();
    end
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    model_adv();
  endtask

`ifdef NX_DISTRIBUTOR_STATS_EN
  task automatic test_stats();
    do_reset();
    rdy = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      drive(1, nx_direction_t'($urandom_range(0, 3)), $urandom(), 0, NX_NORTH, '0);
      settle();
      n_chk++;
      if (brdy !== 1'b1) $display("FAIL stats_accept[%0d]: got %b want 1", k, brdy);
      else n_pass++;
      model_adv();
    end
    drive(0, NX_NORTH, '0, 0, NX_NORTH, '0);
    #1;
    n_chk++;
    if (bcnt !== 4'd15) $display("FAIL stats_bypass: got %0d want 15", bcnt);
    else n_pass++;
    n_chk++;
    if (ecnt !== 4'd0) $display("FAIL stats_emit: got %0d want 0", ecnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_route();
    test_dual_issue();
    test_conflict_rr();
    test_backpressure();
    test_async_reset();
    test_random();
`ifdef NX_DISTRIBUTOR_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
